scan_display_mux: RTL and testbench

Parametrised, time-multiplexed 7-segment display driver. It generalises the fixed 8-digit scan to N digits and adds a scan prescaler, an anode dead-time between digits, and a per-frame shadow register so a frame never shows torn data. It also adds per-digit decimal points, per-digit blinking and per-group leading-zero suppression. It sits between the controller's BCD fields and the board's active-low SEG/AN pins.

---
 rtl/scan_display_mux.sv | 183 ++++++++++++++++++
 tb/tb_scan_display_mux.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/scan_display_mux.sv
// scan_display_mux: time-multiplexed N-digit 7-segment driver with scan
// prescaler, anode dead-time, per-frame shadow registers, per-digit decimal
// points and blinking, and per-group leading-zero suppression.
// SEG/AN outputs are active-low and registered.
module scan_display_mux #(
  parameter int DIGITS       = 8,
  parameter int DIV          = 4,
  parameter int BLANK_CYC    = 1,
  parameter int GROUP        = 2,
  parameter int BLINK_FRAMES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   uDigits,
  input  logic [DIGITS-1:0]     uDp,
  input  logic [DIGITS-1:0]     uBlink,
  input  logic                  uLzs,
  output logic [7:0]            ySEG_,
  output logic [DIGITS-1:0]     yAN_,
  output logic                  yFrame
);

  localparam int PW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] POS_MAX = PW'(DIGITS - 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);
  localparam logic [DW-1:0] BLANK_V = DW'(BLANK_CYC);
  localparam logic [FW-1:0] FRM_MAX = FW'(BLINK_FRAMES - 1);

  logic [DW-1:0]         div_cnt_q, div_cnt_d;
  logic [PW-1:0]         pos_q, pos_d;
  logic [FW-1:0]         frame_cnt_q, frame_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  logic [4*DIGITS-1:0]   sh_dig_q, sh_dig_d;
  logic [DIGITS-1:0]     sh_dp_q, sh_dp_d;
  logic [DIGITS-1:0]     sh_blink_q, sh_blink_d;
  logic                  load_pending_q, load_pending_d;
  logic [7:0]            seg_q, seg_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic                  frame_q, frame_d;

  logic                  slot_end, boundary;
  logic [DIGITS-1:0]     lzs_blank;
  logic                  hi_zero;
  logic [3:0]            grp_code;
  logic [3:0]            cur_code;
  logic                  cur_dp, cur_blink, cur_lzs;
  logic [7:0]            cur_seg;

  function automatic logic [7:0] seg_enc(input logic [3:0] c);
    case (c)
      4'd0:    seg_enc = 8'hC0;
      4'd1:    seg_enc = 8'hF9;
      4'd2:    seg_enc = 8'hA4;
      4'd3:    seg_enc = 8'hB0;
      4'd4:    seg_enc = 8'h99;
      4'd5:    seg_enc = 8'h92;
      4'd6:    seg_enc = 8'h82;
      4'd7:    seg_enc = 8'hF8;
      4'd8:    seg_enc = 8'h80;
      4'd9:    seg_enc = 8'h90;
      default: seg_enc = 8'hFF;
    endcase
  endfunction

  // Leading-zero suppression: walk each group from its top digit down; the
  // lowest digit of a group is never suppressed so a group of zeros shows "0".
  always_comb begin
    lzs_blank = '0;
    hi_zero   = 1'b1;
    grp_code  = 4'd0;
    for (int g = 0; g < DIGITS / GROUP; g++) begin
      hi_zero = 1'b1;
      for (int k = GROUP - 1; k >= 0; k--) begin
        grp_code = sh_dig_q[(g*GROUP + k)*4 +: 4];
        if (k != 0)
          lzs_blank[g*GROUP + k] = uLzs && (grp_code == 4'd0) && hi_zero;
        hi_zero = hi_zero && ((grp_code == 4'd0) || (grp_code >= 4'd10));
      end
    end
  end

  // Select the shadowed attributes of the digit currently being scanned.
  always_comb begin
    cur_code  = 4'hF;
    cur_dp    = 1'b0;
    cur_blink = 1'b0;
    cur_lzs   = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (pos_q == PW'(i)) begin
        cur_code  = sh_dig_q[i*4 +: 4];
        cur_dp    = sh_dp_q[i];
        cur_blink = sh_blink_q[i];
        cur_lzs   = lzs_blank[i];
      end
    end
  end

  // Scan counters, frame/shadow bookkeeping and next registered outputs.
  always_comb begin
    div_cnt_d      = div_cnt_q;
    pos_d          = pos_q;
    frame_cnt_d    = frame_cnt_q;
    blink_phase_d  = blink_phase_q;
    sh_dig_d       = sh_dig_q;
    sh_dp_d        = sh_dp_q;
    sh_blink_d     = sh_blink_q;
    load_pending_d = load_pending_q;
    seg_d          = 8'hFF;
    an_d           = '1;
    cur_seg        = 8'hFF;

    slot_end = (div_cnt_q == DIV_MAX);
    boundary = load_pending_q || (slot_end && (pos_q == POS_MAX));

    if (slot_end) begin
      div_cnt_d = '0;
      pos_d     = (pos_q == POS_MAX) ? '0 : pos_q + PW'(1);
    end else begin
      div_cnt_d = div_cnt_q + DW'(1);
    end

    if (boundary) begin
      sh_dig_d       = uDigits;
      sh_dp_d        = uDp;
      sh_blink_d     = uBlink;
      load_pending_d = 1'b0;
      if (frame_cnt_q == FRM_MAX) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FW'(1);
      end
    end

    if (div_cnt_q >= BLANK_V) begin
      an_d = ~(DIGITS'(1) << pos_q);
      if (!(cur_blink && blink_phase_q)) begin
        cur_seg = ((cur_code >= 4'd10) || cur_lzs) ? 8'hFF : seg_enc(cur_code);
        if (cur_dp) cur_seg[7] = 1'b0;
      end
      seg_d = cur_seg;
    end

    frame_d = boundary;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q      <= '0;
      pos_q          <= '0;
      frame_cnt_q    <= '0;
      blink_phase_q  <= 1'b0;
      sh_dig_q       <= '1;
      sh_dp_q        <= '0;
      sh_blink_q     <= '0;
      load_pending_q <= 1'b1;
      seg_q          <= 8'hFF;
      an_q           <= '1;
      frame_q        <= 1'b0;
    end else begin
      div_cnt_q      <= div_cnt_d;
      pos_q          <= pos_d;
      frame_cnt_q    <= frame_cnt_d;
      blink_phase_q  <= blink_phase_d;
      sh_dig_q       <= sh_dig_d;
      sh_dp_q        <= sh_dp_d;
      sh_blink_q     <= sh_blink_d;
      load_pending_q <= load_pending_d;
      seg_q          <= seg_d;
      an_q           <= an_d;
      frame_q        <= frame_d;
    end
  end

  assign ySEG_  = seg_q;
  assign yAN_   = an_q;
  assign yFrame = frame_q;

endmodule

// File: tb/tb_scan_display_mux.sv
// Testbench for scan_display_mux: cycle-level behavioural model derived from
// the scan arithmetic (elapsed clocks since reset), plus directed scenarios
// with literal expected segment patterns.
module tb_scan_display_mux;

  localparam int DIGITS       = 8;
  localparam int DIV          = 4;
  localparam int BLANK_CYC    = 1;
  localparam int GROUP        = 2;
  localparam int BLINK_FRAMES = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [4*DIGITS-1:0] uDigits;
  logic [DIGITS-1:0]   uDp;
  logic [DIGITS-1:0]   uBlink;
  logic                uLzs;
  logic [7:0]          ySEG_;
  logic [DIGITS-1:0]   yAN_;
  logic                yFrame;

  int errors = 0;
  int checks = 0;

  scan_display_mux #(
    .DIGITS(DIGITS), .DIV(DIV), .BLANK_CYC(BLANK_CYC),
    .GROUP(GROUP), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk(clk), .rst(rst), .uDigits(uDigits), .uDp(uDp), .uBlink(uBlink),
    .uLzs(uLzs), .ySEG_(ySEG_), .yAN_(yAN_), .yFrame(yFrame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                           8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  bit                  mvalid = 0;
  int                  e, nb;
  bit                  pend;
  logic [4*DIGITS-1:0] m_dig;
  logic [DIGITS-1:0]   m_dp, m_bl;
  logic [7:0]          exp_seg;
  logic [DIGITS-1:0]   exp_an;
  logic                exp_frame;

  function automatic logic [7:0] model_seg(input int p, input int phase);
    logic [3:0] code, cq;
    logic [7:0] s;
    int lo;
    bit lz;
    code = m_dig[p*4 +: 4];
    lo = (p / GROUP) * GROUP;
    lz = uLzs && (code == 4'd0) && (p != lo);
    for (int q = p + 1; q < lo + GROUP; q++) begin
      cq = m_dig[q*4 +: 4];
      if (cq >= 4'd1 && cq <= 4'd9) lz = 0;
    end
    if (m_bl[p] && phase == 1) return 8'hFF;
    s = (code > 4'd9 || lz) ? 8'hFF : tab[code];
    if (m_dp[p]) s[7] = 1'b0;
    return s;
  endfunction

  // Expected outputs after each edge, from clocks elapsed since reset.
  always @(posedge clk) begin
    int div, p, phase;
    bit bnd;
    if (rst) begin
      mvalid = 1; e = 0; nb = 0; pend = 1;
      m_dig = '1; m_dp = '0; m_bl = '0;
      exp_seg = 8'hFF; exp_an = '1; exp_frame = 0;
    end else begin
      div   = e % DIV;
      p     = (e / DIV) % DIGITS;
      phase = (nb / BLINK_FRAMES) % 2;
      if (div < BLANK_CYC) begin
        exp_seg = 8'hFF; exp_an = '1;
      end else begin
        exp_an  = ~(DIGITS'(1) << p);
        exp_seg = model_seg(p, phase);
      end
      bnd = pend || (div == DIV - 1 && p == DIGITS - 1);
      exp_frame = bnd;
      if (bnd) begin
        m_dig = uDigits; m_dp = uDp; m_bl = uBlink;
        nb++; pend = 0;
      end
      e++;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (mvalid) begin
      chk("model_seg", 32'(ySEG_), 32'(exp_seg));
      chk("model_an", 32'(yAN_), 32'(exp_an));
      chk("model_frame", 32'(yFrame), 32'(exp_frame));
      chk("an_onehot", 32'($countones(~yAN_) <= 1), 32'd1);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_slot(input int p, output logic [7:0] seg);
    bit found = 0;
    seg = 8'hxx;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (yAN_ === ~(DIGITS'(1) << p)) begin found = 1; seg = ySEG_; end
    end
    if (!found) chk("wait_slot_timeout", 32'(p), 32'hFFFF_FFFF);
  endtask

  task automatic wait_frame(output int cyc);
    bit found = 0;
    cyc = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      cyc++;
      if (yFrame === 1'b1) found = 1;
    end
    if (!found) chk("wait_frame_timeout", 32'(cyc), 32'hFFFF_FFFF);
  endtask

  logic [7:0] plain_exp [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
  logic [7:0] lzs_on    [8] = '{8'h90, 8'hFF, 8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'h92, 8'hFF};
  logic [7:0] lzs_off   [8] = '{8'h90, 8'hC0, 8'hC0, 8'hC0, 8'hFF, 8'hFF, 8'h92, 8'hC0};

  initial begin
    logic [7:0] s;
    int cyc, nblank;
    bit blk [4];

    // 1. reset with arbitrary inputs
    rst = 1; uDigits = 32'h1234ABCD; uDp = 8'h5A; uBlink = 8'hC3; uLzs = 1;
    repeat (3) begin
      @(negedge clk);
      chk("reset_seg", 32'(ySEG_), 32'hFF);
      chk("reset_an", 32'(yAN_), 32'hFF);
      chk("reset_frame", 32'(yFrame), 32'd0);
    end

    // 2. plain scan
    uDigits = 32'h76543210; uDp = '0; uBlink = '0; uLzs = 0;
    rst = 0;
    @(negedge clk);
    chk("first_frame_pulse", 32'(yFrame), 32'd1);
    chk("first_an_idle", 32'(yAN_), 32'hFF);
    wait_frame(cyc);
    wait_frame(cyc);
    chk("frame_period", 32'(cyc), 32'd32);
    for (int p = 0; p < DIGITS; p++) begin
      wait_slot(p, s);
      chk($sformatf("plain_d%0d", p), 32'(s), 32'(plain_exp[p]));
    end

    // 3. leading-zero suppression on and off
    uDigits = 32'h05FA0009; uLzs = 1;
    wait_frame(cyc);
    for (int p = 0; p < DIGITS; p++) begin
      wait_slot(p, s);
      chk($sformatf("lzs_on_d%0d", p), 32'(s), 32'(lzs_on[p]));
    end
    uLzs = 0;
    wait_frame(cyc);
    for (int p = 0; p < DIGITS; p++) begin
      wait_slot(p, s);
      chk($sformatf("lzs_off_d%0d", p), 32'(s), 32'(lzs_off[p]));
    end

    // 4. shadow: mid-frame input change stays invisible until next frame
    uDigits = 32'h11111111;
    wait_frame(cyc);
    repeat (10) @(negedge clk);
    uDigits = 32'h22222222;
    wait_slot(7, s);
    chk("shadow_old_d7", 32'(s), 32'hF9);
    wait_frame(cyc);
    wait_slot(0, s);
    chk("shadow_new_d0", 32'(s), 32'hA4);

    // 5. blink on digit 0, decimal point on digit 3
    uDigits = 32'h76543210; uBlink = 8'h01; uDp = 8'h08;
    wait_frame(cyc);
    wait_slot(3, s);
    chk("dp_d3", 32'(s), 32'h30);
    nblank = 0;
    for (int f = 0; f < 4; f++) begin
      wait_slot(0, s);
      blk[f] = (s == 8'hFF);
      if (blk[f]) nblank++;
      else chk($sformatf("blink_vis_f%0d", f), 32'(s), 32'hC0);
      wait_frame(cyc);
    end
    chk("blink_blank_count", 32'(nblank), 32'd2);
    chk("blink_half_period", 32'(blk[0] != blk[2]), 32'd1);

    // 6. reset in the middle of a frame
    uBlink = '0; uDp = '0;
    wait_slot(5, s);
    rst = 1; uDigits = 32'h89012345;
    @(negedge clk);
    chk("midrst_seg", 32'(ySEG_), 32'hFF);
    chk("midrst_an", 32'(yAN_), 32'hFF);
    chk("midrst_frame", 32'(yFrame), 32'd0);
    rst = 0;
    @(negedge clk);
    chk("midrst_reload_pulse", 32'(yFrame), 32'd1);
    cyc = 0;
    while (yAN_ === '1 && cyc < 20) begin @(negedge clk); cyc++; end
    chk("midrst_first_an", 32'(yAN_), 32'hFE);
    chk("midrst_first_seg", 32'(ySEG_), 32'h92);

    repeat (40) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
